// File: rtl/uart_rx_fifo.sv
// UART receive front end: synchroniser, majority-vote bit sampler, framing FSM
// with false-start rejection and break detection, and a FWFT character FIFO.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      parity_mode,
  input  logic                            rxd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_BITS-1:0]            out_data,
  output logic                            out_perr,
  output logic                            out_ferr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            break_det
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_BITS + 2;
  localparam int unsigned NB_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic [DIV_W-1:0]       bc_q, bc_d, div_q, div_d;
  logic [1:0]             mode_q, mode_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [NB_W-1:0]        nbit_q, nbit_d;
  logic                   perr_q, perr_d;
  logic                   push_q, push_d;
  logic [ENT_W-1:0]       went_q, went_d;
  logic                   brk_q, brk_d;

  logic             rxs, fall, maj, par_en;
  logic [DIV_W-1:0] ctr;
  logic             at_c, at_cm1, at_cm2, wrap;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign fall   = rxs_prev_q & ~rxs;
  assign ctr    = div_q >> 1;
  assign at_c   = (bc_q == ctr);
  assign at_cm1 = (bc_q == ctr - DIV_W'(1));
  assign at_cm2 = (bc_q == ctr - DIV_W'(2));
  assign wrap   = (bc_q == div_q - DIV_W'(1));
  assign maj    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
  assign par_en = (mode_q == 2'd1) || (mode_q == 2'd2);

  // Input synchroniser and edge-detect history; line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxs_prev_q <= rxs;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      div_q   <= '0;
      mode_q  <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      nbit_q  <= '0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      went_q  <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      nbit_q  <= nbit_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
      went_q  <= went_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic; the edge-detect cycle counts as bc = 0 so every decision
  // lands exactly c cycles after the edge and baud_div cycles apart thereafter.
  always_comb begin
    state_d = state_q;
    bc_d    = wrap ? '0 : bc_q + DIV_W'(1);
    div_d   = div_q;
    mode_d  = mode_q;
    samp_d  = samp_q;
    data_d  = data_q;
    nbit_d  = nbit_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    went_d  = went_q;
    brk_d   = 1'b0;
    if (at_cm2) samp_d[0] = rxs;
    if (at_cm1) samp_d[1] = rxs;
    case (state_q)
      S_IDLE: begin
        bc_d = '0;
        if (fall) begin
          div_d   = baud_div;
          mode_d  = parity_mode;
          bc_d    = DIV_W'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (at_c) begin
          nbit_d  = '0;
          perr_d  = 1'b0;
          state_d = maj ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_c) begin
          data_d = {maj, data_q[DATA_BITS-1:1]};
          nbit_d = nbit_q + NB_W'(1);
          if (nbit_q == NB_W'(DATA_BITS - 1)) begin
            state_d = par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (at_c) begin
          perr_d  = ((^data_q) ^ maj) != (mode_q == 2'd2);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_c) begin
          if (!maj && (data_q == '0)) begin
            brk_d   = 1'b1;
            state_d = S_BRKWAIT;
          end else begin
            push_d  = 1'b1;
            went_d  = {~maj, perr_q, data_q};
            state_d = S_IDLE;
          end
        end
      end
      S_BRKWAIT: begin
        bc_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] level_q;
  logic             full, pop, do_push;
  logic [ENT_W-1:0] head;

  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign do_push = push_q & (~full | pop);
  assign head    = mem_q[rd_q];

  // FIFO storage; contents need no reset because reads are gated by level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= went_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (pop)     rd_q <= rd_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(pop);
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? head[DATA_BITS-1:0] : '0;
  assign out_perr   = out_valid & head[DATA_BITS];
  assign out_ferr   = out_valid & head[DATA_BITS+1];
  assign fifo_level = level_q;
  assign overflow   = push_q & full & ~pop;
  assign break_det  = brk_q;

endmodule
